// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing controller: datapath width, op codes
// and controller state encoding.
package alu_pkg;

  localparam int unsigned N = 32;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted. Purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       gidx
);

  always_comb begin
    grant = 2'b00;
    gidx  = 1'b0;
    case (req)
      2'b01: begin
        grant = 2'b01;
        gidx  = 1'b0;
      end
      2'b10: begin
        grant = 2'b10;
        gidx  = 1'b1;
      end
      2'b11: begin
        if (last) begin
          grant = 2'b01;
          gidx  = 1'b0;
        end else begin
          grant = 2'b10;
          gidx  = 1'b1;
        end
      end
      default: begin
        grant = 2'b00;
        gidx  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept, one execute cycle, then a registered result held until handshake.
module alu_share_ctrl
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req_a0,
  input  logic [N-1:0] req_b0,
  input  logic [2:0]   req_op0,
  input  logic [N-1:0] req_a1,
  input  logic [N-1:0] req_b1,
  input  logic [2:0]   req_op1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [N-1:0] rsp_r,
  output logic         rsp_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_r
);

  state_e       state_q;
  logic [N-1:0] op_a_q;
  logic [N-1:0] op_b_q;
  logic [2:0]   op_code_q;
  logic         cur_q;
  logic         last_q;
  logic [1:0]   rsp_valid_q;
  logic [N-1:0] rsp_r_q;
  logic         rsp_err_q;

  logic [1:0]   grant_s;
  logic         gidx_s;

  rr_arb2 u_arb (
    .req   (req_valid),
    .last  (last_q),
    .grant (grant_s),
    .gidx  (gidx_s)
  );

  // Gated by rst so req_ready reads zero while reset is held
  assign req_ready = ((state_q == IDLE) && !rst) ? grant_s : 2'b00;

  // An illegal op would leave the ALU output stale, so the ALU is parked on add
  assign alu_a  = op_a_q;
  assign alu_b  = op_b_q;
  assign alu_op = op_legal(op_code_q) ? op_code_q : OP_ADD;

  assign rsp_valid = rsp_valid_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_code_q   <= 3'd0;
      cur_q       <= 1'b0;
      last_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_r_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            op_a_q    <= gidx_s ? req_a1  : req_a0;
            op_b_q    <= gidx_s ? req_b1  : req_b0;
            op_code_q <= gidx_s ? req_op1 : req_op0;
            cur_q     <= gidx_s;
            last_q    <= gidx_s;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          if (op_legal(op_code_q)) begin
            rsp_r_q   <= alu_r;
            rsp_err_q <= 1'b0;
          end else begin
            rsp_r_q   <= '0;
            rsp_err_q <= 1'b1;
          end
          rsp_valid_q <= cur_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[cur_q]) begin
            rsp_valid_q <= 2'b00;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [2:0]  req_op0, req_op1, alu_op;
  logic [31:0] rsp_r, alu_a, alu_b, alu_r;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  // Reference model state: one outstanding transaction at most
  bit          m_busy, m_resp, m_who, m_last, m_err;
  logic [31:0] m_a, m_b, m_res;
  logic [2:0]  m_op;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_r = alu_fn(alu_a, alu_b, alu_op);

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r)
  );

  function automatic logic [1:0] grant_of(input logic [1:0] v, input bit last);
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return last ? 2'b01 : 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_resp = 1'b0; m_who = 1'b0; m_last = 1'b1; m_err = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_res = 32'd0; m_op = 3'd0;
  endtask

  task automatic model_update();
    logic [1:0] g;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      g = grant_of(req_valid, m_last);
      if (g != 2'b00) begin
        m_who  = (g == 2'b10);
        m_last = m_who;
        m_a    = m_who ? req_a1  : req_a0;
        m_b    = m_who ? req_b1  : req_b0;
        m_op   = m_who ? req_op1 : req_op0;
        m_busy = 1'b1;
        m_resp = 1'b0;
      end
    end else if (!m_resp) begin
      m_err  = (m_op > 3'd4);
      m_res  = m_err ? 32'd0 : alu_fn(m_a, m_b, m_op);
      m_resp = 1'b1;
    end else if (rsp_ready[m_who]) begin
      m_busy = 1'b0;
      m_resp = 1'b0;
    end
  endtask

  task automatic compare();
    logic [1:0] e_rdy, e_vld;
    e_rdy = 2'b00;
    e_vld = 2'b00;
    if (rst) model_reset();
    if (!rst && !m_busy) e_rdy = grant_of(req_valid, m_last);
    if (m_busy && m_resp) e_vld = m_who ? 2'b10 : 2'b01;
    chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
    chk("m_rsp_valid", 32'(rsp_valid), 32'(e_vld));
    if (e_vld != 2'b00 || rst) begin
      chk("m_rsp_r", rsp_r, m_res);
      chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
    end
    chk("m_alu_a", alu_a, m_a);
    chk("m_alu_b", alu_b, m_b);
    chk("m_alu_op", 32'(alu_op), (m_op > 3'd4) ? 32'd0 : 32'(m_op));
  endtask

  // One cycle: compare on the falling edge, advance the model on the rising edge
  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a0 = a; req_b0 = b; req_op0 = op;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_a1 = a; req_b1 = b; req_op1 = op;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    set0(32'd0, 32'd0, 3'd0);
    set1(32'd0, 32'd0, 3'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_r", rsp_r, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_alu_a", alu_a, 32'd0);
    chk("reset_alu_op", 32'(alu_op), 32'd0);

    // Single add
    set0(32'd5, 32'd7, 3'd0); req_valid = 2'b01; #1;
    chk("add_grant", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00; #1;
    chk("add_exec_alu_a", alu_a, 32'd5);
    step();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_r", rsp_r, 32'd12);
    chk("add_rsp_err", 32'(rsp_err), 32'd0);
    step();
    chk("add_one_cycle", 32'(rsp_valid), 32'd0);

    // Subtract with wrap, requester 1
    set1(32'd0, 32'd1, 3'd1); req_valid = 2'b10; #1;
    chk("sub_grant", 32'(req_ready), 32'd2);
    step(); req_valid = 2'b00; #1;
    chk("sub_exec_alu_op", 32'(alu_op), 32'd1);
    step();
    chk("sub_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("sub_rsp_r", rsp_r, 32'hFFFF_FFFF);
    step();

    // Contention: grants alternate starting with requester 0
    set0(32'hF0F0_1234, 32'h0FF0_FFFF, 3'd4);
    set1(32'hFFFF_0000, 32'h1234_5678, 3'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_grant", 32'(req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
      step();
      step();
      chk("cont_rsp_valid", 32'(rsp_valid), (k % 2 == 1) ? 32'd2 : 32'd1);
      chk("cont_rsp_r", rsp_r, (k % 2 == 1) ? 32'h1234_0000 : 32'hFF00_EDCB);
      step();
    end

    // Backpressure on requester 0 with requester 1 waiting
    set0(32'd3, 32'd4, 3'd3);
    set1(32'd10, 32'd4, 3'd1);
    req_valid = 2'b11; rsp_ready = 2'b00; #1;
    chk("bp_grant0", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b10; #1;
    chk("bp_exec_no_ready", 32'(req_ready), 32'd0);
    step();
    rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_r", rsp_r, 32'd7);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      if (i == 3) rsp_ready = 2'b01;
      step();
    end
    chk("bp_next_grant", 32'(req_ready), 32'd2);
    rsp_ready = 2'b11;
    step(); req_valid = 2'b00;
    step();
    chk("bp_rsp1_valid", 32'(rsp_valid), 32'd2);
    chk("bp_rsp1_r", rsp_r, 32'd6);
    step();

    // Illegal op code
    set0(32'd1, 32'd2, 3'd6); req_valid = 2'b01; #1;
    chk("ill_grant", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00; #1;
    chk("ill_exec_alu_op", 32'(alu_op), 32'd0);
    step();
    chk("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_rsp_r", rsp_r, 32'd0);
    chk("ill_rsp_err", 32'(rsp_err), 32'd1);
    step();

    // Reset while executing
    set0(32'd9, 32'd1, 3'd0); req_valid = 2'b01;
    step(); req_valid = 2'b00; rst = 1'b1; #1;
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd0);
    chk("rstmid_alu_a", alu_a, 32'd0);
    chk("rstmid_alu_b", alu_b, 32'd0);
    chk("rstmid_rsp_err", 32'(rsp_err), 32'd0);
    step(); rst = 1'b0;
    step();
    chk("rstmid_no_pulse", 32'(rsp_valid), 32'd0);
    set0(32'd20, 32'd22, 3'd0); req_valid = 2'b01; #1;
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    step(); req_valid = 2'b00;
    step();
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_r", rsp_r, 32'd42);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Controller that shares one combinational N-bit ALU (ops: add, sub, and, or, xor) between two requesters, e.g. the execute stage and the address/branch unit. It arbitrates round-robin, latches the winning operands, drives the ALU for one execute cycle, and returns a registered result with a valid/ready response handshake. It sits between the requesters and the single ALU instance. It is the only block allowed to drive the ALU's operand and op inputs.

## Interface
- N, 32, datapath width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid[1:0]  in  2  request valid, one bit per requester
- req_ready[1:0]  out  2  request accepted this cycle (one-hot or zero)
- req_a0, req_b0 / req_a1, req_b1  in  N each  operands per requester
- req_op0 / req_op1  in  3  op code per requester
- rsp_valid[1:0]  out  2  response valid, at most one bit high
- rsp_ready[1:0]  in  2  requester accepts response
- rsp_r  out  N  result, shared by both requesters and qualified by rsp_valid
- rsp_err  out  1  op code illegal (op > 4); rsp_r = 0
- alu_a, alu_b  out  N  to ALU operands
- alu_op  out  3  to ALU op
- alu_r  in  N  from ALU result

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any req_valid is high, grant one requester: req_ready[g]=1 combinationally this cycle.
  - Latch its a, b and op into op_a, op_b and op_code. Store g in cur, set last=g.
  - Go to EXEC.
  - If no request, stay in IDLE.
- **Arbitration:** round-robin on last.
  - Both requesters valid: grant the one that is not last.
  - One requester valid: grant it.
  - last resets to 1, so requester 0 wins the first tie.
- **EXEC**
  - If op_code ≤ 4: capture alu_r into res; err=0.
  - Otherwise: res=0, err=1. The ALU output is ignored because an undefined op leaves the ALU output stale.
  - Go to RESP.
- **RESP**
  - rsp_valid[cur]=1, rsp_r=res, rsp_err=err, all held stable.
  - On rsp_ready[cur]: go to IDLE.
  - rsp_ready of the other requester is ignored.
- **ALU drive:** alu_a/alu_b/alu_op are driven from op_a/op_b/op_code at all times. alu_op is forced to 3'h0 when op_code > 4.
- **Sub semantics:** B − A convention is not allowed. Result is A − B (A + ~B + 1) mod 2^N. All arithmetic wraps mod 2^N with no flags.
- req_ready is never high outside IDLE. Requesters hold req_* stable while req_valid is high and req_ready is low.

## Timing
- **Reset values:** state=IDLE, req_ready=0, rsp_valid=0, rsp_r=0, rsp_err=0, alu_a=alu_b=0, alu_op=0, last=1.
- **Latency:** accept at cycle T → EXEC at T+1 → rsp_valid high from T+2.
- **Response hold:** rsp_valid stays high until the rsp_ready handshake. With rsp_ready tied high, valid lasts exactly 1 cycle.
- **Throughput:** the next accept is no earlier than the cycle after the response handshake, i.e. at most 1 op per 3 cycles.
- **Simultaneous events:**
  - req_valid arriving during EXEC/RESP waits and is not dropped.
  - A new request in the same cycle as the response handshake is not accepted until the next cycle (IDLE).
- **rst mid-operation:** returns to IDLE immediately (async). The pending result is discarded and no response is emitted.

## Structure
- Shared package alu_pkg:
  - op code constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4, OP_MAX=4
  - state encoding IDLE/EXEC/RESP
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], last.
  - Outputs: grant[1:0] (one-hot or zero), gidx.
  - Purely combinational.
- The ALU is instantiated outside. This block only drives its ports.

## Test plan
- **Single add:** req0 a=5, b=7, op=0, rsp_ready=1 → req_ready[0] at T, rsp_valid[0] at T+2 with rsp_r=12, rsp_err=0, held 1 cycle.
- **Sub wrap:** req1 a=0, b=1, op=1 → rsp_r=32'hFFFF_FFFF on rsp_valid[1]. Also check alu_op=1 during EXEC.
- **Contention:** both valid continuously with xor/and ops → grants alternate 0,1,0,1 starting with 0 after reset. Each response goes to the correct rsp_valid bit with the correct result.
- **Backpressure:** rsp_ready[0]=0 for 4 cycles → rsp_valid[0]/rsp_r stable for 4 cycles. req_ready stays 0 throughout; the pending req1 is granted the cycle after the handshake.
- **Illegal op:** op=6 → rsp_r=0, rsp_err=1. alu_op=0 during EXEC.
- **Reset mid-op:** assert rst during EXEC → next cycle all outputs are at reset values and no rsp_valid pulse. After release, a new req0 completes normally.
